wishbone_rr_arbiter: RTL and testbench
======================================

WISHBONE_RR_ARBITER -- requirements
Module: wishbone_rr_arbiter

Interface
REQ-001 SHALL have parameter NM, default 2: number of masters, 2..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: data width; select width SW = DATA_WIDTH/8.
REQ-004 SHALL have parameter TAG_WIDTH, default 4: tag width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit, 1..65535.
REQ-006 SHALL have port sys_clk, input, 1: the one clock; all state updates on its rising edge.
REQ-007 SHALL have port sys_rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have ports masters_cyc/stb/we, input, NM each: per-master bus controls, master i at bit i.
REQ-009 SHALL have ports masters_tag/sel/adr/mosi, input, NM×TAG_WIDTH/SW/ADDR_WIDTH/DATA_WIDTH: flattened master fields, master i at slice i.
REQ-010 SHALL have ports masters_miso, output, NM×DATA_WIDTH, and masters_ack/err, output, NM each: per-master responses.
REQ-011 SHALL have ports slave_cyc/stb/we/tag/sel/adr/mosi, output, widths as for one master: the shared slave request.
REQ-012 SHALL have ports slave_miso, input, DATA_WIDTH, and slave_ack/err, input, 1 each: the shared slave response.
REQ-013 SHALL have port grant, output, NM: registered one-hot grant, all zero when idle.

Function
REQ-014 SHALL implement two states: IDLE and GRANT.
REQ-015 In IDLE with any masters_cyc high, SHALL latch the winner into grant and enter GRANT at the next edge.
REQ-016 SHALL pick the winner round-robin: the search starts at index last+1 mod NM, where last is the most recently granted master (reset value NM-1, so master 0 has first priority).
REQ-017 In GRANT, SHALL route the granted master's cyc/stb/we/tag/sel/adr/mosi combinationally to slave_*.
REQ-018 In GRANT, SHALL route slave_miso/ack/err combinationally to the granted master only; all other masters see miso=0, ack=0, err=0.
REQ-019 In IDLE, SHALL drive all slave_* outputs and all master responses to 0.
REQ-020 In GRANT, SHALL hold the grant while the granted master's cyc stays high, regardless of other requests (no preemption).
REQ-021 When the granted master's cyc is low at an edge, SHALL return to IDLE, clear grant and update last; re-arbitration therefore costs exactly one IDLE cycle.
REQ-022 Latency SHALL be: request to grant = 1 cycle; slave ack to master ack = 0 cycles.
REQ-023 When several masters request in the same IDLE cycle, SHALL grant exactly one and keep the others pending, each held off for at most NM-1 grants.
REQ-024 SHALL ignore the stb of non-granted masters.

Reset
REQ-025 sys_rst high SHALL immediately (asynchronously) force IDLE, grant=0 and last=NM-1, and clear the watchdog counter.
REQ-026 Because all outputs derive from the state, SHALL force every output to 0 during reset, including a reset that arrives mid-transfer.
REQ-027 After sys_rst is deasserted, SHALL arbitrate from IDLE on the first edge.

Configuration
REQ-028 Macro WB_ARB_TIMEOUT_EN SHALL control the bus watchdog.
REQ-029 With WB_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL increment each GRANT cycle in which slave_stb=1 and slave_ack=slave_err=0.
- The counter clears on ack, on err, or on leaving GRANT.
REQ-030 With WB_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the arbiter SHALL, for one cycle:
- assert err to the granted master;
- force slave_cyc=slave_stb=0;
- clear the counter.
The grant is kept until that master drops cyc.
REQ-031 With WB_ARB_TIMEOUT_EN undefined, SHALL contain no counter, and master err SHALL equal the routed slave_err only.

Verification
REQ-032 NM=2; master0 raises cyc/stb at cycle 0 -> grant=01 at cycle 1; slave ack at cycle 3 -> masters_ack=01 in cycle 3; master1 sees ack=0.
REQ-033 Both masters hold cyc from cycle 0, each releasing after 1 ack -> grant sequence 01, 00, 10, 00, 01; strict alternation.
REQ-034 Master1 granted; master0 requests meanwhile -> grant stays 10 until master1 drops cyc, then one cycle of 00, then 01.
REQ-035 sys_rst pulsed while grant=01 with stb high -> slave_cyc=0 and grant=00 in the same cycle, before any edge; after release master0 is re-granted first.
REQ-036 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> masters_err pulses 1 for one cycle after 4 stalled cycles, with slave_stb=0 that cycle.
REQ-037 Same stimulus without WB_ARB_TIMEOUT_EN -> no err; grant held indefinitely.

Source files
------------

// File: rtl/wishbone_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wishbone_rr_arbiter
//
// Round-robin arbiter letting NM Wishbone masters share one slave port.
// A two-state FSM (IDLE / GRANT) latches one winner per arbitration. The
// winner's request is routed combinationally to the slave and the slave's
// response is routed back to the winner only. Ownership lasts until the winner
// drops cyc, so there is no preemption. Every hand-over passes through exactly
// one IDLE cycle.
//
// Optional feature (compile-time macro WB_ARB_TIMEOUT_EN):
//   Adds a 16-bit bus watchdog. When a strobed access stalls for
//   TIMEOUT_CYCLES cycles without ack/err, the granted master receives a
//   one-cycle err and slave_cyc/slave_stb are dropped for that cycle.
//
// Ports
//   sys_clk, sys_rst         clock, asynchronous active-high reset
//   masters_cyc/stb/we       per-master controls, master i at bit i
//   masters_tag/sel/adr/mosi flattened master request fields, master i at slice i
//   masters_miso/ack/err     per-master responses (zero unless granted)
//   slave_cyc..slave_mosi    shared slave request
//   slave_miso/ack/err       shared slave response
//   grant                    registered one-hot grant, zero when idle
// -----------------------------------------------------------------------------
module wishbone_rr_arbiter #(
  parameter  int NM             = 2,
  parameter  int ADDR_WIDTH     = 32,
  parameter  int DATA_WIDTH     = 32,
  parameter  int TAG_WIDTH      = 4,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int SW             = DATA_WIDTH / 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NM-1:0]            masters_cyc,
  input  logic [NM-1:0]            masters_stb,
  input  logic [NM-1:0]            masters_we,
  input  logic [NM*TAG_WIDTH-1:0]  masters_tag,
  input  logic [NM*SW-1:0]         masters_sel,
  input  logic [NM*ADDR_WIDTH-1:0] masters_adr,
  input  logic [NM*DATA_WIDTH-1:0] masters_mosi,
  output logic [NM*DATA_WIDTH-1:0] masters_miso,
  output logic [NM-1:0]            masters_ack,
  output logic [NM-1:0]            masters_err,
  output logic                     slave_cyc,
  output logic                     slave_stb,
  output logic                     slave_we,
  output logic [TAG_WIDTH-1:0]     slave_tag,
  output logic [SW-1:0]            slave_sel,
  output logic [ADDR_WIDTH-1:0]    slave_adr,
  output logic [DATA_WIDTH-1:0]    slave_mosi,
  input  logic [DATA_WIDTH-1:0]    slave_miso,
  input  logic                     slave_ack,
  input  logic                     slave_err,
  output logic [NM-1:0]            grant
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  if (NM < 2 || NM > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("wishbone_rr_arbiter: parameter out of range");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state;
  logic [NM-1:0]   r_grant;
  logic [IW-1:0]   r_gidx;   // index of the granted master
  logic [IW-1:0]   r_last;   // most recently granted master

  logic            w_act;
  logic            w_release;
  logic            w_timeout;
  logic            w_found;
  logic [IW-1:0]   w_win;

  logic [TAG_WIDTH-1:0]  w_tag  [NM];
  logic [SW-1:0]         w_sel  [NM];
  logic [ADDR_WIDTH-1:0] w_adr  [NM];
  logic [DATA_WIDTH-1:0] w_mosi [NM];

  assign w_act     = (r_state == S_GRANT);
  assign w_release = w_act & ~masters_cyc[r_gidx];
  assign grant     = r_grant;

  // Round-robin search: first requester above r_last, then wrap to the
  // lowest index up to and including r_last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NM; i++) begin
      if (!w_found && (i > int'(r_last)) && masters_cyc[i]) begin
        w_found = 1'b1;
        w_win   = IW'(i);
      end
    end
    for (int i = 0; i < NM; i++) begin
      if (!w_found && (i <= int'(r_last)) && masters_cyc[i]) begin
        w_found = 1'b1;
        w_win   = IW'(i);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(NM - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_gidx  <= w_win;
            r_grant <= {{(NM-1){1'b0}}, 1'b1} << w_win;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= r_gidx;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] r_wdog;

  // Counts stalled strobe cycles; the cycle in which it equals the limit
  // is the abort cycle, which also clears it.
  assign w_timeout = w_act & (r_wdog == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wdog <= '0;
    end else if (!w_act || w_release || slave_ack || slave_err || w_timeout) begin
      r_wdog <= '0;
    end else if (slave_stb) begin
      r_wdog <= r_wdog + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  genvar gi;
  for (gi = 0; gi < NM; gi++) begin : g_m
    assign w_tag[gi]  = masters_tag[gi*TAG_WIDTH +: TAG_WIDTH];
    assign w_sel[gi]  = masters_sel[gi*SW +: SW];
    assign w_adr[gi]  = masters_adr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_mosi[gi] = masters_mosi[gi*DATA_WIDTH +: DATA_WIDTH];
    // r_grant is all-zero in IDLE, so responses vanish there automatically.
    assign masters_ack[gi] = r_grant[gi] & slave_ack;
    assign masters_err[gi] = r_grant[gi] & (slave_err | w_timeout);
    assign masters_miso[gi*DATA_WIDTH +: DATA_WIDTH] = r_grant[gi] ? slave_miso : '0;
  end

  assign slave_cyc  = w_act & masters_cyc[r_gidx] & ~w_timeout;
  assign slave_stb  = w_act & masters_stb[r_gidx] & ~w_timeout;
  assign slave_we   = w_act & masters_we[r_gidx];
  assign slave_tag  = w_act ? w_tag[r_gidx]  : '0;
  assign slave_sel  = w_act ? w_sel[r_gidx]  : '0;
  assign slave_adr  = w_act ? w_adr[r_gidx]  : '0;
  assign slave_mosi = w_act ? w_mosi[r_gidx] : '0;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
module tb_wishbone_rr_arbiter;

  localparam int NM = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int SW = DW / 8;
  localparam int TO = 40;

  logic               clk = 1'b0;
  logic               rst;
  logic [NM-1:0]      masters_cyc, masters_stb, masters_we;
  logic [NM*TW-1:0]   masters_tag;
  logic [NM*SW-1:0]   masters_sel;
  logic [NM*AW-1:0]   masters_adr;
  logic [NM*DW-1:0]   masters_mosi;
  logic [NM*DW-1:0]   masters_miso;
  logic [NM-1:0]      masters_ack, masters_err;
  logic               slave_cyc, slave_stb, slave_we;
  logic [TW-1:0]      slave_tag;
  logic [SW-1:0]      slave_sel;
  logic [AW-1:0]      slave_adr;
  logic [DW-1:0]      slave_mosi;
  logic [DW-1:0]      slave_miso;
  logic               slave_ack, slave_err;
  logic [NM-1:0]      grant;

  wishbone_rr_arbiter #(
    .NM(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(clk), .sys_rst(rst),
    .masters_cyc(masters_cyc), .masters_stb(masters_stb), .masters_we(masters_we),
    .masters_tag(masters_tag), .masters_sel(masters_sel), .masters_adr(masters_adr),
    .masters_mosi(masters_mosi), .masters_miso(masters_miso),
    .masters_ack(masters_ack), .masters_err(masters_err),
    .slave_cyc(slave_cyc), .slave_stb(slave_stb), .slave_we(slave_we),
    .slave_tag(slave_tag), .slave_sel(slave_sel), .slave_adr(slave_adr),
    .slave_mosi(slave_mosi), .slave_miso(slave_miso),
    .slave_ack(slave_ack), .slave_err(slave_err), .grant(grant)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [NM-1:0] cyc;
    logic [NM-1:0] stb;
    logic          ack;
    logic [NM-1:0] e_grant;
    logic          e_scyc;
    logic          e_sstb;
    logic [NM-1:0] e_mack;
    logic [AW-1:0] e_adr;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  // reference model state
  int owner;
  int last;

  initial begin
    // master i presents address 0x100+i during directed tests
    tbl[0]  = '{3'b001, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 16'h0000};
    tbl[1]  = '{3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 1'b1, 3'b000, 16'h0100};
    tbl[2]  = '{3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 1'b1, 3'b000, 16'h0100};
    tbl[3]  = '{3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001, 16'h0100};
    tbl[4]  = '{3'b000, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 16'h0100};
    tbl[5]  = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 16'h0000};
    tbl[6]  = '{3'b111, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 16'h0000};
    tbl[7]  = '{3'b111, 3'b111, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000, 16'h0101};
    tbl[8]  = '{3'b101, 3'b101, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 16'h0101};
    tbl[9]  = '{3'b101, 3'b101, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 16'h0000};
    tbl[10] = '{3'b101, 3'b101, 1'b1, 3'b100, 1'b1, 1'b1, 3'b100, 16'h0102};
    tbl[11] = '{3'b001, 3'b001, 1'b0, 3'b100, 1'b0, 1'b0, 3'b000, 16'h0102};
    tbl[12] = '{3'b001, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 16'h0000};
    tbl[13] = '{3'b011, 3'b011, 1'b0, 3'b001, 1'b1, 1'b1, 3'b000, 16'h0100};
    tbl[14] = '{3'b011, 3'b011, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001, 16'h0100};
    tbl[15] = '{3'b011, 3'b010, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 16'h0100};
    tbl[16] = '{3'b010, 3'b010, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 16'h0100};
    tbl[17] = '{3'b010, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 16'h0000};
    tbl[18] = '{3'b010, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000, 16'h0101};
    tbl[19] = '{3'b000, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0, 3'b010, 16'h0101};
    tbl[20] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 16'h0000};

    masters_we   = '0;
    masters_tag  = '0;
    masters_sel  = '1;
    masters_adr  = {16'h0102, 16'h0101, 16'h0100};
    masters_mosi = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    slave_miso   = 32'h5A5A_1234;
    slave_ack    = 1'b0;
    slave_err    = 1'b0;

    // reset holds everything at zero even with requests and a slave ack present
    rst         = 1'b1;
    masters_cyc = '1;
    masters_stb = '1;
    slave_ack   = 1'b1;
    #2;
    chk("reset_grant", grant, 0);
    chk("reset_scyc", slave_cyc, 0);
    chk("reset_mack", masters_ack, 0);
    chk("reset_miso", masters_miso, 0);
    @(negedge clk);
    #1;
    chk("reset_grant_after_edge", grant, 0);
    masters_cyc = '0;
    masters_stb = '0;
    slave_ack   = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // directed table: each row is one clock cycle
    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      masters_cyc = tbl[r].cyc;
      masters_stb = tbl[r].stb;
      slave_ack   = tbl[r].ack;
      #1;
      chk($sformatf("tbl%0d_grant", r), grant, tbl[r].e_grant);
      chk($sformatf("tbl%0d_scyc", r), slave_cyc, tbl[r].e_scyc);
      chk($sformatf("tbl%0d_sstb", r), slave_stb, tbl[r].e_sstb);
      chk($sformatf("tbl%0d_mack", r), masters_ack, tbl[r].e_mack);
      chk($sformatf("tbl%0d_adr", r), slave_adr, tbl[r].e_adr);
    end

    // reset arriving mid-transfer clears outputs before any edge
    @(negedge clk);
    masters_cyc = 3'b001;
    masters_stb = 3'b001;
    slave_ack   = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_pre_grant", grant, 3'b001);
    chk("mid_pre_scyc", slave_cyc, 1);
    #1;
    rst       = 1'b1;
    slave_ack = 1'b1;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_scyc", slave_cyc, 0);
    chk("mid_rst_sstb", slave_stb, 0);
    chk("mid_rst_mack", masters_ack, 0);
    @(negedge clk);
    rst         = 1'b0;
    slave_ack   = 1'b0;
    masters_cyc = 3'b011;
    masters_stb = 3'b011;
    @(negedge clk);
    #1;
    chk("post_rst_first_grant", grant, 3'b001);
    @(negedge clk);
    masters_cyc = '0;
    masters_stb = '0;
    @(negedge clk);
    @(negedge clk);

    // stalled slave: master0 holds a strobe and the slave never answers
    masters_cyc = 3'b001;
    masters_stb = 3'b001;
    slave_ack   = 1'b0;
    slave_err   = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stall%0d_grant", n), grant, 3'b001);
`ifdef WB_ARB_TIMEOUT_EN
      if (n == TO) begin
        chk($sformatf("stall%0d_err", n), masters_err, 3'b001);
        chk($sformatf("stall%0d_sstb", n), slave_stb, 0);
      end else begin
        chk($sformatf("stall%0d_err", n), masters_err, 3'b000);
        chk($sformatf("stall%0d_sstb", n), slave_stb, 1);
      end
`else
      chk($sformatf("stall%0d_err", n), masters_err, 3'b000);
      chk($sformatf("stall%0d_sstb", n), slave_stb, 1);
`endif
    end
    @(negedge clk);
    masters_cyc = '0;
    masters_stb = '0;

    // randomized traffic against the reference model, from a fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    owner = -1;
    last  = NM - 1;
    for (int cyc_n = 0; cyc_n < 2000; cyc_n++) begin
      logic [NM-1:0]    c;
      logic [NM-1:0]    e_grant, e_ack, e_err;
      logic [NM*DW-1:0] e_miso;
      @(negedge clk);
      c = masters_cyc;
      for (int i = 0; i < NM; i++) begin
        if (c[i]) c[i] = ($urandom_range(0, 7) != 0);
        else      c[i] = ($urandom_range(0, 2) == 0);
        masters_tag[i*TW +: TW]  = TW'($urandom);
        masters_sel[i*SW +: SW]  = SW'($urandom);
        masters_adr[i*AW +: AW]  = AW'($urandom);
        masters_mosi[i*DW +: DW] = $urandom;
      end
      masters_cyc = c;
      masters_stb = NM'($urandom);
      masters_we  = NM'($urandom);
      slave_miso  = $urandom;
      slave_ack   = ($urandom_range(0, 3) == 0);
      slave_err   = ($urandom_range(0, 7) == 0);
      #1;
      e_grant = '0;
      e_ack   = '0;
      e_err   = '0;
      e_miso  = '0;
      if (owner >= 0) begin
        e_grant[owner] = 1'b1;
        e_ack[owner]   = slave_ack;
        e_err[owner]   = slave_err;
        e_miso[owner*DW +: DW] = slave_miso;
        chk("rnd_scyc", slave_cyc, masters_cyc[owner]);
        chk("rnd_sstb", slave_stb, masters_stb[owner]);
        chk("rnd_swe", slave_we, masters_we[owner]);
        chk("rnd_stag", slave_tag, masters_tag[owner*TW +: TW]);
        chk("rnd_ssel", slave_sel, masters_sel[owner*SW +: SW]);
        chk("rnd_sadr", slave_adr, masters_adr[owner*AW +: AW]);
        chk("rnd_smosi", slave_mosi, masters_mosi[owner*DW +: DW]);
      end else begin
        chk("rnd_idle_slave", {slave_cyc, slave_stb, slave_we, slave_tag, slave_sel, slave_adr, slave_mosi}, 0);
      end
      chk("rnd_grant", grant, e_grant);
      chk("rnd_mack", masters_ack, e_ack);
      chk("rnd_merr", masters_err, e_err);
      chk("rnd_mmiso", masters_miso, e_miso);
      // advance model across the coming edge
      if (owner < 0) begin
        for (int k = 1; k <= NM; k++) begin
          int idx;
          idx = (last + k) % NM;
          if (owner < 0 && masters_cyc[idx]) owner = idx;
        end
      end else if (!masters_cyc[owner]) begin
        last  = owner;
        owner = -1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
